branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised branch resolution unit for the MIPS pipeline. It predicts in ID with a pattern history table (PHT) of 2-bit saturating counters, latches the branch into an internal EX register, and resolves the full MIPS conditional-branch set against forwarded operands in EX. On a misprediction it raises flush and supplies the redirect PC. The PHT trains on every retiring branch, and two performance counters track branches and mispredictions.

## Interface
- `DATA_W`, 32, operand width
- `ADDR_W`, 32, PC width
- `PHT_ENTRIES`, 16, PHT depth; power of two, ≥2; `IDX_W = $clog2(PHT_ENTRIES)`
- `CNT_INIT`, 2'b01, counter reset value (weakly not-taken)
- `PERF_W`, 32, performance counter width
- `clk` in 1 — clock
- `rst_n` in 1 — reset; one clock; reset is asynchronous and active-low
- `id_valid` in 1 — an instruction is present in ID
- `id_opcode` in 6 — instruction opcode in ID
- `id_rt` in 5 — rt field in ID, used to decode REGIMM
- `id_pc` in ADDR_W — PC of the instruction in ID
- `id_imm` in 16 — branch offset
- `ex_hold` in 1 — EX stall; hold the EX register
- `flush_in` in 1 — external kill of the ID/EX contents
- `ex_rs_val` in DATA_W — forwarded rs operand in EX
- `ex_rt_val` in DATA_W — forwarded rt operand in EX
- `id_pred_taken` out 1 — prediction for the ID branch
- `id_pred_target` out ADDR_W — predicted target
- `ex_valid` out 1 — the EX register holds a branch
- `ex_taken` out 1 — resolved outcome
- `ex_link` out 1 — the branch is BLTZAL/BGEZAL and is taken (link write enable)
- `flush` out 1 — misprediction; squash the younger instructions
- `redirect_pc` out ADDR_W — correct next fetch PC when `flush`=1
- `perf_branches` out PERF_W — retired branch count
- `perf_mispred` out PERF_W — retired misprediction count

## Operation
- **Decode (ID).** Recognised branches:
  - BEQ 000100: rs==rt
  - BNE 000101: rs!=rt
  - BLEZ 000110: rs≤0 (signed)
  - BGTZ 000111: rs>0 (signed)
  - REGIMM 000001 with rt 00000 BLTZ (rs<0), 00001 BGEZ (rs≥0), 10000 BLTZAL (rs<0, link), 10001 BGEZAL (rs≥0, link)
  - Any other opcode/rt combination is not a branch. It does not enter EX as valid, and `id_pred_taken`=0.
- **Target.** target = id_pc + 4 + (sign-extended imm << 2), computed modulo 2^ADDR_W. Fall-through = id_pc + 8 (the delay slot is always executed).
- **Prediction.** PHT index = id_pc[IDX_W+1:2]. `id_pred_taken` = counter[1] for a recognised branch; `id_pred_target` = target.
- **ID→EX capture.** On each edge with `ex_hold`=0, the EX register loads {is_branch & id_valid, condition code, link flag, pred_taken, target, fall-through, PHT index}.
  - `flush_in`=1 loads valid=0 and overrides `ex_hold`.
  - `ex_hold`=1 with `flush_in`=0 keeps the register unchanged.
- **Resolution (EX, combinational).**
  - `ex_taken` = valid & condition(ex_rs_val, ex_rt_val).
  - `flush` = valid & (ex_taken != pred_taken).
  - `redirect_pc` = ex_taken ? target : fall-through. It is 0 when `flush`=0.
- **Retire.** A branch retires on an edge where valid=1, `ex_hold`=0 and `flush_in`=0. On retire:
  - The PHT entry increments, saturating at 3, if taken; otherwise it decrements, saturating at 0.
  - `perf_branches` increments.
  - `perf_mispred` increments if `flush`.
  - Both performance counters saturate at all-ones.
  - A held branch updates exactly once. A branch killed by `flush_in` does not update.
- **Read/write collision.** When the ID read and the EX update address the same PHT entry, the prediction uses the pre-update value; there is no bypass.

## Timing
- The ID→EX latency is 1 cycle. Prediction is combinational in ID. Resolution and `flush` are combinational in EX, in the same cycle the operands are valid.
- PHT updates and performance-counter updates occur at the retire edge.
- Reset (async assert, sync release):
  - All PHT entries = CNT_INIT.
  - EX valid = 0, so `ex_valid`, `ex_taken`, `ex_link`, `flush` = 0 and `redirect_pc` = 0.
  - `perf_*` = 0.
- If reset asserts mid-operation, a pending branch is dropped with no PHT update.
- Back-to-back branches in consecutive cycles are supported: retire of N and capture of N+1 happen on the same edge.

## Structure
- Shared package `branch_pkg` holds:
  - the opcode constants (OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM);
  - the REGIMM rt codes;
  - the condition enum `br_cond_t` {EQ, NE, LEZ, GTZ, LTZ, GEZ};
  - the 2-bit counter constants.
- Sub-module `branch_pht`: the PHT_ENTRIES×2-bit counter array, with an async-read port, a single saturating-update write port, and the async reset.

## Test plan
- **Reset state.** Reset → `id_pred_taken`=0 for any BEQ, `ex_valid`=0, `perf_*`=0.
- **Cold BEQ, taken.** BEQ at pc 0x100, imm 0x0004, rs=rt=5 → predicted not-taken; in EX `ex_taken`=1, `flush`=1, `redirect_pc`=0x114; counter 01→10; `perf_mispred`=1.
- **Warm repeat.** Repeat the same BEQ → `id_pred_taken`=1, `flush`=0, counter 10→11, then saturates at 11 on the third taken retire.
- **BGEZAL.** BGEZAL with rs=0 → `ex_taken`=1, `ex_link`=1. BLTZ with rs=0x8000_0000 → taken; BLEZ with rs=1 → not taken, and if mispredicted `redirect_pc`=pc+8.
- **Hold, then kill.** Branch in EX with `ex_hold`=1 for 3 cycles → PHT and `perf_branches` update once, on release. Same branch with `flush_in`=1 → no update, `ex_valid`=0 next cycle.
- **Collision.** Back-to-back branches at pc 0x200 and 0x240 (PHT_ENTRIES=16, same index) → the second prediction uses the pre-update counter; both retire and `perf_branches`=2.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the MIPS branch resolution unit: opcodes, REGIMM
// rt codes, the branch condition encoding and 2-bit counter helpers.
package branch_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef enum logic [2:0] {EQ, NE, LEZ, GTZ, LTZ, GEZ} br_cond_t;

  localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

  // Saturating step of a 2-bit predictor counter toward the actual outcome.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_pht.sv
// Pattern history table: array of 2-bit saturating counters with an
// asynchronous read port and one saturating-update write port.
module branch_pht
  import branch_pkg::*;
#(
  parameter int         ENTRIES  = 16,
  parameter int         IDX_W    = $clog2(ENTRIES),
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] cnt_q [ENTRIES];

  // Read returns the stored value; a same-cycle update is not bypassed.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  // Counter array: reset to CNT_INIT, train one entry per retiring branch.
  // NOTE: this array is reset explicitly because every entry must start at a
  // known prediction state; it is small enough to live in flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= cnt_next(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: predicts in ID from the PHT, holds the branch in
// an EX register, resolves against forwarded operands and trains on retire.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter int         ADDR_W      = 32,
  parameter int         PHT_ENTRIES = 16,
  parameter logic [1:0] CNT_INIT    = 2'b01,
  parameter int         PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [4:0]        id_rt,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [15:0]       id_imm,
  input  logic              ex_hold,
  input  logic              flush_in,
  input  logic [DATA_W-1:0] ex_rs_val,
  input  logic [DATA_W-1:0] ex_rt_val,
  output logic              id_pred_taken,
  output logic [ADDR_W-1:0] id_pred_target,
  output logic              ex_valid,
  output logic              ex_taken,
  output logic              ex_link,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(PHT_ENTRIES);

  typedef struct packed {
    logic              valid;
    br_cond_t          cond;
    logic              link;
    logic              pred;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] fall;
    logic [IDX_W-1:0]  idx;
  } ex_reg_t;

  logic              id_is_br;
  br_cond_t          id_cond;
  logic              id_link;
  logic [IDX_W-1:0]  id_idx;
  logic [1:0]        id_cnt;
  logic [ADDR_W-1:0] id_offset;
  ex_reg_t           ex_d, ex_q;
  logic              cond_true;
  logic              retire;
  logic              rs_neg, rs_zero;
  logic [PERF_W-1:0] perf_br_q, perf_mp_q;

  // Decode the recognised MIPS conditional branches.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    id_is_br = 1'b0;
    id_cond  = EQ;
    id_link  = 1'b0;
    case (id_opcode)
      OP_BEQ:  begin id_is_br = 1'b1; id_cond = EQ;  end
      OP_BNE:  begin id_is_br = 1'b1; id_cond = NE;  end
      OP_BLEZ: begin id_is_br = 1'b1; id_cond = LEZ; end
      OP_BGTZ: begin id_is_br = 1'b1; id_cond = GTZ; end
      OP_REGIMM: begin
        case (id_rt)
          RT_BLTZ:   begin id_is_br = 1'b1; id_cond = LTZ; end
          RT_BGEZ:   begin id_is_br = 1'b1; id_cond = GEZ; end
          RT_BLTZAL: begin id_is_br = 1'b1; id_cond = LTZ; id_link = 1'b1; end
          RT_BGEZAL: begin id_is_br = 1'b1; id_cond = GEZ; id_link = 1'b1; end
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

  assign id_idx         = id_pc[IDX_W+1:2];
  assign id_offset      = {{(ADDR_W-18){id_imm[15]}}, id_imm, 2'b00};
  assign id_pred_target = id_pc + ADDR_W'(4) + id_offset;
  assign id_pred_taken  = id_is_br & id_cnt[1];

  branch_pht #(
    .ENTRIES  (PHT_ENTRIES),
    .IDX_W    (IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_pht (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (id_idx),
    .rd_cnt_o    (id_cnt),
    .upd_en_i    (retire),
    .upd_idx_i   (ex_q.idx),
    .upd_taken_i (ex_taken)
  );

  // Next EX contents: kill wins over hold, hold keeps, otherwise capture ID.
  always_comb begin
    ex_d = ex_q;
    if (flush_in) begin
      ex_d.valid = 1'b0;
    end else if (!ex_hold) begin
      ex_d.valid  = id_is_br & id_valid;
      ex_d.cond   = id_cond;
      ex_d.link   = id_link;
      ex_d.pred   = id_pred_taken;
      ex_d.target = id_pred_target;
      ex_d.fall   = id_pc + ADDR_W'(8);
      ex_d.idx    = id_idx;
    end
  end

  // EX pipeline register; reset drops any pending branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign rs_neg  = ex_rs_val[DATA_W-1];
  assign rs_zero = ~|ex_rs_val;

  // Evaluate the branch condition on the forwarded operands.
  always_comb begin
    cond_true = 1'b0;
    case (ex_q.cond)
      EQ:      cond_true = (ex_rs_val == ex_rt_val);
      NE:      cond_true = (ex_rs_val != ex_rt_val);
      LEZ:     cond_true = rs_neg | rs_zero;
      GTZ:     cond_true = ~rs_neg & ~rs_zero;
      LTZ:     cond_true = rs_neg;
      GEZ:     cond_true = ~rs_neg;
      default: cond_true = 1'b0;
    endcase
  end

  assign ex_valid    = ex_q.valid;
  assign ex_taken    = ex_q.valid & cond_true;
  assign ex_link     = ex_taken & ex_q.link;
  assign flush       = ex_q.valid & (ex_taken != ex_q.pred);
  assign redirect_pc = !flush ? '0 : (ex_taken ? ex_q.target : ex_q.fall);
  assign retire      = ex_q.valid & ~ex_hold & ~flush_in;

  // Saturating performance counters, stepped once per retired branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else if (retire) begin
      if (perf_br_q != '1)          perf_br_q <= perf_br_q + PERF_W'(1);
      if (flush && perf_mp_q != '1) perf_mp_q <= perf_mp_q + PERF_W'(1);
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rt;
  logic [31:0] id_pc;
  logic [15:0] id_imm;
  logic        ex_hold;
  logic        flush_in;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        ex_valid;
  logic        ex_taken;
  logic        ex_link;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;

  // Narrow-counter copy used only to observe performance-counter saturation.
  logic        s_pred_taken, s_ex_valid, s_ex_taken, s_ex_link, s_flush;
  logic [31:0] s_pred_target, s_redirect_pc;
  logic [1:0]  s_perf_branches, s_perf_mispred;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_rt          (id_rt),
    .id_pc          (id_pc),
    .id_imm         (id_imm),
    .ex_hold        (ex_hold),
    .flush_in       (flush_in),
    .ex_rs_val      (ex_rs_val),
    .ex_rt_val      (ex_rt_val),
    .id_pred_taken  (id_pred_taken),
    .id_pred_target (id_pred_target),
    .ex_valid       (ex_valid),
    .ex_taken       (ex_taken),
    .ex_link        (ex_link),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .perf_branches  (perf_branches),
    .perf_mispred   (perf_mispred)
  );

  branch_resolve_unit #(.PERF_W(2)) dut_small (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_rt          (id_rt),
    .id_pc          (id_pc),
    .id_imm         (id_imm),
    .ex_hold        (ex_hold),
    .flush_in       (flush_in),
    .ex_rs_val      (ex_rs_val),
    .ex_rt_val      (ex_rt_val),
    .id_pred_taken  (s_pred_taken),
    .id_pred_target (s_pred_target),
    .ex_valid       (s_ex_valid),
    .ex_taken       (s_ex_taken),
    .ex_link        (s_ex_link),
    .flush          (s_flush),
    .redirect_pc    (s_redirect_pc),
    .perf_branches  (s_perf_branches),
    .perf_mispred   (s_perf_mispred)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_perf(input string tag, input int br, input int mp);
    check({tag, "_perf_br"}, 64'(perf_branches), 64'(br));
    check({tag, "_perf_mp"}, 64'(perf_mispred), 64'(mp));
  endtask

  // One branch through ID then EX; retire happens on the edge after return.
  task automatic run_br(input string tag, input logic [5:0] op, input logic [4:0] rt,
                        input logic [31:0] pc, input logic [15:0] imm,
                        input logic [31:0] rs_v, input logic [31:0] rt_v,
                        input logic e_pred, input logic [31:0] e_tgt,
                        input logic e_taken, input logic e_link, input logic [31:0] e_redir);
    @(negedge clk);
    id_valid = 1'b1; id_opcode = op; id_rt = rt; id_pc = pc; id_imm = imm;
    #1;
    check({tag, "_pred"}, 64'(id_pred_taken), 64'(e_pred));
    check({tag, "_tgt"}, 64'(id_pred_target), 64'(e_tgt));
    @(negedge clk);
    id_valid = 1'b0; ex_rs_val = rs_v; ex_rt_val = rt_v;
    #1;
    check({tag, "_exv"}, 64'(ex_valid), 64'd1);
    check({tag, "_taken"}, 64'(ex_taken), 64'(e_taken));
    check({tag, "_link"}, 64'(ex_link), 64'(e_link));
    check({tag, "_flush"}, 64'(flush), 64'(e_pred != e_taken));
    check({tag, "_redir"}, 64'(redirect_pc), 64'(e_redir));
  endtask

  task automatic non_branch(input string tag, input logic [5:0] op, input logic [4:0] rt);
    @(negedge clk);
    id_valid = 1'b1; id_opcode = op; id_rt = rt; id_pc = 32'h100; id_imm = 16'h4;
    #1 check({tag, "_pred"}, 64'(id_pred_taken), 64'd0);
    @(negedge clk);
    id_valid = 1'b0;
    #1 check({tag, "_exv"}, 64'(ex_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b1; id_opcode = OP_BEQ; id_rt = '0;
    id_pc = 32'h100; id_imm = 16'h4; ex_hold = 1'b0; flush_in = 1'b0;
    ex_rs_val = '0; ex_rt_val = '0;
    #3;
    check("rst_pred", 64'(id_pred_taken), 64'd0);
    check("rst_exv", 64'(ex_valid), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_redir", 64'(redirect_pc), 64'd0);
    check_perf("rst", 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; id_valid = 1'b0;

    // PHT idx0: 01 -> 10 -> 11 -> 11 -> 10 -> 11
    run_br("beq_cold",   OP_BEQ, 5'd0, 32'h100, 16'h0004, 32'd5, 32'd5, 1'b0, 32'h114, 1'b1, 1'b0, 32'h114);
    @(negedge clk); #1 check_perf("cold", 1, 1);
    check("cold_exv_drop", 64'(ex_valid), 64'd0);
    run_br("beq_warm",   OP_BEQ, 5'd0, 32'h100, 16'h0004, 32'd5, 32'd5, 1'b1, 32'h114, 1'b1, 1'b0, 32'h0);
    run_br("beq_sat",    OP_BEQ, 5'd0, 32'h100, 16'h0004, 32'd5, 32'd5, 1'b1, 32'h114, 1'b1, 1'b0, 32'h0);
    run_br("beq_nt",     OP_BEQ, 5'd0, 32'h100, 16'h0004, 32'd5, 32'd6, 1'b1, 32'h114, 1'b0, 1'b0, 32'h108);
    run_br("bne_neg",    OP_BNE, 5'd0, 32'h100, 16'hFFFC, 32'd1, 32'd2, 1'b1, 32'h0F4, 1'b1, 1'b0, 32'h0);
    @(negedge clk); #1 check_perf("warm", 5, 2);

    // idx1: 01 -> 10 -> 01, idx2: 01 -> 10
    run_br("bgezal",     OP_REGIMM, RT_BGEZAL, 32'h104, 16'h0010, 32'h0, 32'h0, 1'b0, 32'h148, 1'b1, 1'b1, 32'h148);
    run_br("bltz",       OP_REGIMM, RT_BLTZ,   32'h108, 16'h0008, 32'h8000_0000, 32'h0, 1'b0, 32'h12C, 1'b1, 1'b0, 32'h12C);
    run_br("blez",       OP_BLEZ, 5'd0, 32'h104, 16'h0020, 32'd1, 32'h0, 1'b1, 32'h188, 1'b0, 1'b0, 32'h10C);
    run_br("bgtz_neg",   OP_BGTZ, 5'd0, 32'h10C, 16'h0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h114, 1'b0, 1'b0, 32'h0);
    run_br("bltzal_nt",  OP_REGIMM, RT_BLTZAL, 32'h118, 16'h0002, 32'd5, 32'h0, 1'b0, 32'h124, 1'b0, 1'b0, 32'h0);
    @(negedge clk); #1 check_perf("cond", 10, 5);

    non_branch("jump", 6'b000010, 5'd0);
    non_branch("regimm_bad", OP_REGIMM, 5'b00010);
    #1 check_perf("nonbr", 10, 5);

    // Hold for three edges: exactly one update on release (idx4: 01 -> 10).
    @(negedge clk);
    id_valid = 1'b1; id_opcode = OP_BEQ; id_rt = '0; id_pc = 32'h110; id_imm = 16'h0010;
    #1 check("hold_pred", 64'(id_pred_taken), 64'd0);
    @(negedge clk);
    id_valid = 1'b0; ex_rs_val = 32'd7; ex_rt_val = 32'd7; ex_hold = 1'b1;
    #1 check("hold_flush", 64'(flush), 64'd1);
    check("hold_redir", 64'(redirect_pc), 64'h154);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("hold_perf", 64'(perf_branches), 64'd10);
      check("hold_exv", 64'(ex_valid), 64'd1);
    end
    ex_hold = 1'b0;
    @(negedge clk); #1 check_perf("release", 11, 6);
    check("release_exv", 64'(ex_valid), 64'd0);
    // A single update leaves idx4 at 10; one not-taken retire brings it to 01.
    run_br("hold_once",  OP_BEQ, 5'd0, 32'h110, 16'h0010, 32'd7, 32'd8, 1'b1, 32'h154, 1'b0, 1'b0, 32'h118);

    // Kill with hold also asserted: no update, EX empty next cycle.
    @(negedge clk);
    id_valid = 1'b1; id_opcode = OP_BEQ; id_pc = 32'h110; id_imm = 16'h0010;
    #1 check("kill_pred", 64'(id_pred_taken), 64'd0);
    @(negedge clk);
    id_valid = 1'b0; ex_rs_val = 32'd7; ex_rt_val = 32'd7; flush_in = 1'b1; ex_hold = 1'b1;
    #1 check("kill_exv_before", 64'(ex_valid), 64'd1);
    @(negedge clk);
    flush_in = 1'b0; ex_hold = 1'b0;
    #1 check("kill_exv_after", 64'(ex_valid), 64'd0);
    check_perf("kill", 12, 7);
    run_br("kill_noupd", OP_BEQ, 5'd0, 32'h110, 16'h0010, 32'd7, 32'd8, 1'b0, 32'h154, 1'b0, 1'b0, 32'h0);

    // Collision on idx0: bring it to 10, then back-to-back not-taken branches.
    run_br("coll_prep",  OP_BEQ, 5'd0, 32'h100, 16'h0000, 32'd1, 32'd2, 1'b1, 32'h104, 1'b0, 1'b0, 32'h108);
    @(negedge clk);
    id_valid = 1'b1; id_opcode = OP_BEQ; id_pc = 32'h200; id_imm = 16'h0000;
    #1 check("coll_a_pred", 64'(id_pred_taken), 64'd1);
    check("coll_a_tgt", 64'(id_pred_target), 64'h204);
    @(negedge clk);
    id_pc = 32'h240; ex_rs_val = 32'd1; ex_rt_val = 32'd2;
    #1 check("coll_a_flush", 64'(flush), 64'd1);
    check("coll_a_redir", 64'(redirect_pc), 64'h208);
    check("coll_b_pred", 64'(id_pred_taken), 64'd1);
    check("coll_b_tgt", 64'(id_pred_target), 64'h244);
    @(negedge clk);
    id_valid = 1'b0;
    #1 check("coll_b_exv", 64'(ex_valid), 64'd1);
    check("coll_b_flush", 64'(flush), 64'd1);
    check("coll_b_redir", 64'(redirect_pc), 64'h248);
    @(negedge clk);
    #1 check_perf("coll", 16, 10);
    check("sat_perf_br", 64'(s_perf_branches), 64'd3);
    check("sat_perf_mp", 64'(s_perf_mispred), 64'd3);

    // Asynchronous reset mid-operation: pending branch dropped, PHT reinitialised.
    @(negedge clk);
    id_valid = 1'b1; id_opcode = OP_BEQ; id_pc = 32'h108; id_imm = 16'h0000;
    #1 check("mid_pred_before", 64'(id_pred_taken), 64'd1);
    @(negedge clk);
    ex_rs_val = 32'd3; ex_rt_val = 32'd3;
    #1 check("mid_exv_before", 64'(ex_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_exv", 64'(ex_valid), 64'd0);
    check("mid_flush", 64'(flush), 64'd0);
    check("mid_redir", 64'(redirect_pc), 64'd0);
    check("mid_pred", 64'(id_pred_taken), 64'd0);
    check_perf("mid", 0, 0);
    @(negedge clk);
    rst_n = 1'b1; id_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
